// File: rtl/spectro_frame_engine.sv
// Spectrogram frame engine: counts synchronised channel edges per RTC frame, snapshots and serialises them.
// Define SPECTRO_PARITY_EN to append an even-parity bit to every serial word.
module spectro_frame_engine #(
  parameter int NUM_CH      = 15,
  parameter int CNT_W       = 12,
  parameter int FRAME_TICKS = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_in,
  input  logic                          rtc_in,
  output logic                          serial_out,
  output logic                          bit_valid,
  output logic                          load_out,
  output logic [$clog2(NUM_CH+1)-1:0]   sel_out,
  output logic                          frame_busy,
  output logic                          ovf_ch,
  output logic                          ovf_rtc,
  output logic                          frame_lost
);

  localparam int TW = $clog2(FRAME_TICKS + 1);
  localparam int SW = $clog2(NUM_CH + 1);
`ifdef SPECTRO_PARITY_EN
  localparam int W  = CNT_W + 1;
`else
  localparam int W  = CNT_W;
`endif
  localparam int BW = $clog2(W + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [TW-1:0]    TIME_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [TW-1:0]    TIME_FULL = TW'(FRAME_TICKS);
  localparam logic [SW-1:0]    SEL_LAST  = SW'(NUM_CH);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic logic [W-1:0] format_word(input logic [CNT_W-1:0] data);
`ifdef SPECTRO_PARITY_EN
    format_word = {data, ^data};
`else
    format_word = data;
`endif
  endfunction

  logic [NUM_CH-1:0] ch_s1_q, ch_s2_q, ch_s3_q;
  logic              rtc_s1_q, rtc_s2_q, rtc_s3_q;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [TW-1:0]     time_q, time_d;
  logic [TW-1:0]     shadow_time_q, shadow_time_d;
  logic              ovf_ch_q, ovf_ch_d;
  logic              ovf_rtc_q, ovf_rtc_d;
  logic              frame_lost_q, frame_lost_d;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [W-1:0]      shift_q, shift_d;
  logic              load_q, load_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] ch_edge_s, ch_ovf_s;
  logic              rtc_edge_s, t_ch_s, t_rtc_s, trig_s, accept_s;
  logic [CNT_W-1:0]  time_word_s, word_data_s;

  // Two-flop synchronisers plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_s1_q  <= {NUM_CH{1'b0}};
      ch_s2_q  <= {NUM_CH{1'b0}};
      ch_s3_q  <= {NUM_CH{1'b0}};
      rtc_s1_q <= 1'b0;
      rtc_s2_q <= 1'b0;
      rtc_s3_q <= 1'b0;
    end else begin
      ch_s1_q  <= ch_in;
      ch_s2_q  <= ch_s1_q;
      ch_s3_q  <= ch_s2_q;
      rtc_s1_q <= rtc_in;
      rtc_s2_q <= rtc_s1_q;
      rtc_s3_q <= rtc_s2_q;
    end
  end

  // Edge detection, trigger decode, counters and snapshot capture
  always_comb begin
    ch_edge_s  = ch_s2_q & ~ch_s3_q;
    rtc_edge_s = rtc_s2_q & ~rtc_s3_q;
    ch_ovf_s   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ovf_s[i] = ch_edge_s[i] & (cnt_q[i] == CNT_MAX);
    end
    t_ch_s   = |ch_ovf_s;
    t_rtc_s  = rtc_edge_s & (time_q == TIME_LAST);
    trig_s   = t_ch_s | t_rtc_s;
    accept_s = trig_s & (state_q == IDLE);

    shadow_time_d = shadow_time_q;
    time_d        = time_q;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      cnt_d[i]    = cnt_q[i];
    end

    if (trig_s) begin
      // The overflowing edge is consumed; other coincident edges open the next frame
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_s) begin
          shadow_d[i] = ch_ovf_s[i] ? CNT_MAX : cnt_q[i];
        end else begin
          shadow_d[i] = shadow_q[i];
        end
        cnt_d[i] = (ch_edge_s[i] & ~ch_ovf_s[i]) ? CNT_W'(1) : CNT_W'(0);
      end
      if (accept_s) begin
        shadow_time_d = t_rtc_s ? TIME_FULL : time_q;
      end else begin
        shadow_time_d = shadow_time_q;
      end
      time_d = (rtc_edge_s & ~t_rtc_s) ? TW'(1) : TW'(0);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_edge_s[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
      if (rtc_edge_s) begin
        time_d = time_q + TW'(1);
      end else begin
        time_d = time_q;
      end
    end

    ovf_ch_d     = t_ch_s;
    ovf_rtc_d    = t_rtc_s;
    frame_lost_d = trig_s & ~accept_s;
  end

  // Counter, shadow and status-pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= {CNT_W{1'b0}};
        shadow_q[i] <= {CNT_W{1'b0}};
      end
      time_q        <= {TW{1'b0}};
      shadow_time_q <= {TW{1'b0}};
      ovf_ch_q      <= 1'b0;
      ovf_rtc_q     <= 1'b0;
      frame_lost_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      time_q        <= time_d;
      shadow_time_q <= shadow_time_d;
      ovf_ch_q      <= ovf_ch_d;
      ovf_rtc_q     <= ovf_rtc_d;
      frame_lost_q  <= frame_lost_d;
    end
  end

  // Word select: time word (size cast zero-extends or keeps LSBs) then channel shadows
  always_comb begin
    time_word_s = CNT_W'(shadow_time_q);
    word_data_s = time_word_s;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == SW'(i + 1)) begin
        word_data_s = shadow_q[i];
      end else begin
        word_data_s = word_data_s;
      end
    end
  end

  // Serialiser next-state: LOAD for one cycle, then W shift cycles per word
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        sel_d   = {SW{1'b0}};
        shift_d = {W{1'b0}};
        if (accept_s) begin
          state_d = LOAD;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      LOAD: begin
        shift_d = format_word(word_data_s);
        bit_d   = {BW{1'b0}};
        valid_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_q == BIT_LAST) begin
          shift_d = {W{1'b0}};
          bit_d   = {BW{1'b0}};
          if (sel_q == SEL_LAST) begin
            state_d = IDLE;
            sel_d   = {SW{1'b0}};
            busy_d  = 1'b0;
          end else begin
            state_d = LOAD;
            sel_d   = sel_q + SW'(1);
            load_d  = 1'b1;
          end
        end else begin
          shift_d = shift_q << 1;
          bit_d   = bit_q + BW'(1);
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = {SW{1'b0}};
        shift_d = {W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // Serialiser state and registered output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= {SW{1'b0}};
      bit_q   <= {BW{1'b0}};
      shift_q <= {W{1'b0}};
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign serial_out = shift_q[W-1];
  assign bit_valid  = valid_q;
  assign load_out   = load_q;
  assign sel_out    = sel_q;
  assign frame_busy = busy_q;
  assign ovf_ch     = ovf_ch_q;
  assign ovf_rtc    = ovf_rtc_q;
  assign frame_lost = frame_lost_q;

endmodule
